fixed_divider: RTL and testbench

FIXED_DIVIDER -- requirements
Module: fixed_divider

---
 rtl/fixed_pkg.sv | 22 ++
 rtl/fixed_divider.sv | 191 +++++++++++++++++++
 tb/tb_fixed_divider.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fixed_pkg.sv
// ============================================================================
// Module : fixed_pkg
// Shared defaults and FSM state type for the sign-magnitude fixed divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fixed_pkg;

  localparam int FIXED_WIDTH     = 12;
  localparam int FIXED_FRAC_BITS = 6;
  localparam int FIXED_INT_BITS  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fixed_divider.sv
// ============================================================================
// Module : fixed_divider
// Sign-magnitude fixed-point restoring divider, one quotient bit per cycle.
// Define FIXED_DIVIDER_ROUND_EN for round-to-nearest instead of truncation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fixed_divider
  import fixed_pkg::*;
#(
  parameter int WIDTH     = FIXED_WIDTH,
  parameter int FRAC_BITS = FIXED_FRAC_BITS,
  parameter int INT_BITS  = FIXED_INT_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int MAG_W = INT_BITS + FRAC_BITS;
  localparam int N     = MAG_W + FRAC_BITS;
  localparam int CNT_W = $clog2(N);

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic               sign_a_q, sign_a_d;
  logic [MAG_W-1:0]   mag_b_q, mag_b_d;
  logic [N-1:0]       dvd_q, dvd_d;
  logic [MAG_W-1:0]   rem_q, rem_d;
  logic [N-2:0]       quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;

  logic [MAG_W:0]     rem_shift;
  logic               fits;
  logic [MAG_W-1:0]   rem_next;
  logic [N-1:0]       quo_next;
  logic               hi_set;
  logic               sat;
  logic [MAG_W-1:0]   mag_fin;
  logic               sign_fin;
  logic               last_step;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q, dvd_q[N-1]};
    fits      = (rem_shift >= {1'b0, mag_b_q});
    rem_next  = fits ? MAG_W'(rem_shift - {1'b0, mag_b_q}) : rem_shift[MAG_W-1:0];
    quo_next  = {quo_q, fits};
    hi_set    = |quo_next[N-1:MAG_W];
    last_step = (cnt_q == CNT_W'(N - 1));
  end

`ifdef FIXED_DIVIDER_ROUND_EN
  logic           round_up;
  logic [MAG_W:0] rounded;

  // A rounded-up all-ones magnitude carries out and must saturate too.
  always_comb begin
    round_up = ({rem_next, 1'b0} >= {1'b0, mag_b_q});
    rounded  = {1'b0, quo_next[MAG_W-1:0]} + {{MAG_W{1'b0}}, round_up};
    sat      = hi_set | rounded[MAG_W];
    mag_fin  = sat ? {MAG_W{1'b1}} : rounded[MAG_W-1:0];
  end
`else
  always_comb begin
    sat     = hi_set;
    mag_fin = sat ? {MAG_W{1'b1}} : quo_next[MAG_W-1:0];
  end
`endif

  assign sign_fin = sign_q & (|mag_fin);

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    sign_a_d = sign_a_q;
    mag_b_d  = mag_b_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    quot_d   = quot_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
          sign_a_d = a[WIDTH-1];
          mag_b_d  = b[MAG_W-1:0];
          dvd_d    = {a[MAG_W-1:0], {FRAC_BITS{1'b0}}};
          rem_d    = '0;
          quo_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end

      CALC: begin
        if (mag_b_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = {sign_a_q, {MAG_W{1'b1}}};
          ovf_d   = 1'b1;
          dbz_d   = 1'b1;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next[N-2:0];
          dvd_d = {dvd_q[N-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            quot_d  = {sign_fin, mag_fin};
            ovf_d   = sat;
            dbz_d   = 1'b0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      sign_a_q <= 1'b0;
      mag_b_q  <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      sign_a_q <= sign_a_d;
      mag_b_q  <= mag_b_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      quot_q   <= quot_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quot        = quot_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_fixed_divider.sv
// ============================================================================
// Module : tb_fixed_divider
// Directed bench for fixed_divider with an arithmetic reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fixed_divider;

  localparam int W  = 12;
  localparam int F  = 6;
  localparam int NN = (W - 1) + F;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  quot;
  logic          overflow;
  logic          div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  fixed_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quot        (quot),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference result {div_by_zero, overflow, quot} from plain integer arithmetic.
  function automatic logic [W+1:0] model_div(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned ma, mb, q, r;
    logic            s;
    logic [W-2:0]    mag;
    logic            ov;
    ma = longint'(x[W-2:0]);
    mb = longint'(y[W-2:0]);
    if (mb == 0) return {1'b1, 1'b1, x[W-1], {(W-1){1'b1}}};
    q = (ma << F) / mb;
    r = (ma << F) % mb;
`ifdef FIXED_DIVIDER_ROUND_EN
    if (2 * r >= mb) q = q + 1;
`endif
    ov  = (q > ((1 << (W - 1)) - 1));
    mag = ov ? {(W-1){1'b1}} : q[W-2:0];
    s   = (x[W-1] ^ y[W-1]) && (mag != 0);
    return {1'b0, ov, s, mag};
  endfunction

  // Transaction-level model: 0 idle, 1 busy counting down, 2 done cycle.
  int           ph;
  int           left;
  logic [W+1:0] pend;
  logic [W-1:0] m_quot;
  logic         m_ovf, m_dbz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph     <= 0;
      left   <= 0;
      pend   <= '0;
      m_quot <= '0;
      m_ovf  <= 1'b0;
      m_dbz  <= 1'b0;
    end else begin
      case (ph)
        0: if (start) begin
          pend <= model_div(a, b);
          left <= (b[W-2:0] == 0) ? 1 : NN;
          ph   <= 1;
        end
        1: begin
          left <= left - 1;
          if (left == 1) begin
            ph <= 2;
            {m_dbz, m_ovf, m_quot} <= pend;
          end
        end
        default: ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",        32'(busy),        32'(ph == 1));
      chk("done",        32'(done),        32'(ph == 2));
      chk("quot",        32'(quot),        32'(m_quot));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] eq,
                     input logic eo, input logic ed, input int elat, input bit poke);
    int n;
    bit seen;
    wait_idle();
    #1 start = 1'b1; a = ta; b = tb;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = done;
      if (poke && n == 3) begin
        #1 start = 1'b1; a = 12'h7C0; b = 12'h001;
      end else if (poke && n == 4) begin
        #1 start = 1'b0;
      end
    end
    if (!seen) chk("done_timeout", 32'd1, 32'd0);
    else begin
      chk("latency",     32'(n),           32'(elat));
      chk("lit_quot",    32'(quot),        32'(eq));
      chk("lit_ovf",     32'(overflow),    32'(eo));
      chk("lit_dbz",     32'(div_by_zero), 32'(ed));
      chk("model_pin",   32'(model_div(ta, tb)), 32'({ed, eo, eq}));
    end
  endtask

  task automatic reset_mid();
    int dn;
    wait_idle();
    #1 start = 1'b1; a = 12'h0C0; b = 12'h080;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_ovf",  32'(overflow), 32'd0);
    chk("rst_dbz",  32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    dn = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("no_done_after_abort", 32'(dn), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_quot", 32'(quot), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    run(12'h0C0, 12'h080, 12'h060, 1'b0, 1'b0, 18, 1'b0);
    run(12'h8C0, 12'h080, 12'h860, 1'b0, 1'b0, 18, 1'b0);
    run(12'h7C0, 12'h001, 12'h7FF, 1'b1, 1'b0, 18, 1'b0);
    run(12'h840, 12'h000, 12'hFFF, 1'b1, 1'b1, 2,  1'b0);
`ifdef FIXED_DIVIDER_ROUND_EN
    run(12'h080, 12'h0C0, 12'h02B, 1'b0, 1'b0, 18, 1'b0);
`else
    run(12'h080, 12'h0C0, 12'h02A, 1'b0, 1'b0, 18, 1'b0);
`endif
    run(12'h801, 12'h7C0, 12'h000, 1'b0, 1'b0, 18, 1'b0);
    run(12'h0C0, 12'h8C0, 12'h840, 1'b0, 1'b0, 18, 1'b0);
    run(12'h040, 12'h0C0, 12'h015, 1'b0, 1'b0, 18, 1'b0);
    run(12'h7FF, 12'h040, 12'h7FF, 1'b0, 1'b0, 18, 1'b0);
    run(12'h000, 12'h800, 12'h7FF, 1'b1, 1'b1, 2,  1'b0);
`ifdef FIXED_DIVIDER_ROUND_EN
    run(12'h080, 12'h0C0, 12'h02B, 1'b0, 1'b0, 18, 1'b1);
`else
    run(12'h080, 12'h0C0, 12'h02A, 1'b0, 1'b0, 18, 1'b1);
`endif
    reset_mid();
    run(12'h0C0, 12'h080, 12'h060, 1'b0, 1'b0, 18, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
